// File: rtl/instruction_fetch.sv
// Fetch stage: PC, loadable word-addressed instruction memory and the IF/ID register.
// Optional macro FETCH_PERF_COUNT_EN adds a saturating fetch counter on o_fetch_count.
module instruction_fetch #(
  parameter int          MEM_DEPTH  = 256,
  parameter int          ADDR_W     = 8,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_run,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic              i_redirect,
  input  logic [31:0]       i_target,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [31:0]       i_wr_data,
  output logic [31:0]       o_instr,
  output logic [31:0]       o_pc,
  output logic [31:0]       o_pc_plus4,
  output logic              o_valid,
  output logic              o_halted
`ifdef FETCH_PERF_COUNT_EN
  , output logic [31:0]     o_fetch_count
`endif
);

  typedef enum logic [2:0] {
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_FLUSH,
    ACT_FETCH,
    ACT_HALT_BUBBLE
  } act_e;

  logic [31:0] mem_r [MEM_DEPTH];
  logic [31:0] pc_r;
  logic [31:0] word_s;
  act_e        act_s;

  // PC[1:0] are ignored and upper bits wrap modulo the memory depth.
  assign word_s = mem_r[pc_r[ADDR_W+1:2]];

  // Program load port, only honoured while the core is idle.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_wr_en && !i_run) begin
      mem_r[i_wr_addr] <= i_wr_data;
    end
  end

  // Per-edge action selection in priority order.
  always_comb begin
    act_s = ACT_HOLD;
    if (o_halted) begin
      act_s = ACT_HALT_BUBBLE;
    end else if (!i_run) begin
      act_s = ACT_HOLD;
    end else if (i_redirect) begin
      act_s = ACT_REDIRECT;
    end else if (i_flush) begin
      act_s = ACT_FLUSH;
    end else if (i_stall) begin
      act_s = ACT_HOLD;
    end else begin
      act_s = ACT_FETCH;
    end
  end

  // PC and IF/ID register update.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pc_r       <= 32'd0;
      o_instr    <= 32'd0;
      o_pc       <= 32'd0;
      o_pc_plus4 <= 32'd0;
      o_valid    <= 1'b0;
      o_halted   <= 1'b0;
    end else begin
      case (act_s)
        ACT_REDIRECT: begin
          pc_r    <= i_target & ~32'd3;
          o_instr <= 32'd0;
          o_valid <= 1'b0;
        end
        ACT_FLUSH: begin
          o_instr <= 32'd0;
          o_valid <= 1'b0;
          if (!i_stall) begin
            pc_r <= pc_r + 32'd4;
          end else begin
            pc_r <= pc_r;
          end
        end
        ACT_FETCH: begin
          o_instr    <= word_s;
          o_pc       <= pc_r;
          o_pc_plus4 <= pc_r + 32'd4;
          o_valid    <= 1'b1;
          // A halt word freezes the PC on its own address.
          if (word_s == HALT_INSTR) begin
            o_halted <= 1'b1;
          end else begin
            pc_r <= pc_r + 32'd4;
          end
        end
        ACT_HALT_BUBBLE: begin
          o_instr <= 32'd0;
          o_valid <= 1'b0;
        end
        ACT_HOLD: begin
          pc_r <= pc_r;
        end
        default: begin
          pc_r <= pc_r;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  // Saturating count of real fetches, halt fetch included.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_fetch_count <= 32'd0;
    end else if (act_s == ACT_FETCH && o_fetch_count != 32'hFFFF_FFFF) begin
      o_fetch_count <= o_fetch_count + 32'd1;
    end else begin
      o_fetch_count <= o_fetch_count;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed table, corner sequences, random vs model.
module tb_instruction_fetch;
  localparam int DEPTH = 256;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n, run, stall, flush, redirect, wr_en;
  logic [31:0] target, wr_data;
  logic [7:0]  wr_addr;
  logic [31:0] instr, pc, pc_plus4;
  logic        valid, halted;
`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_count;
`endif

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_pc, m_instr, m_opc, m_p4, m_cnt;
  logic        m_valid, m_halt;

  typedef struct {
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic        exp_halted;
  } vec_t;
  vec_t tbl [5];

  instruction_fetch dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_stall(stall), .i_flush(flush),
    .i_redirect(redirect), .i_target(target), .i_wr_en(wr_en), .i_wr_addr(wr_addr),
    .i_wr_data(wr_data), .o_instr(instr), .o_pc(pc), .o_pc_plus4(pc_plus4),
    .o_valid(valid), .o_halted(halted)
`ifdef FETCH_PERF_COUNT_EN
    , .o_fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] seqw(input int i);
    return 32'h0010_0000 | i;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Spec-level next-state of the fetch stage, evaluated before the edge.
  task automatic model_step();
    logic [31:0] w;
    if (!rst_n) begin
      m_pc = 0; m_instr = 0; m_opc = 0; m_p4 = 0; m_valid = 0; m_halt = 0; m_cnt = 0;
    end else begin
      if (wr_en && !run) m_mem[wr_addr] = wr_data;
      if (m_halt) begin
        m_instr = 0; m_valid = 0;
      end else if (run) begin
        if (redirect) begin
          m_pc = {target[31:2], 2'b00}; m_instr = 0; m_valid = 0;
        end else if (flush) begin
          m_instr = 0; m_valid = 0;
          if (!stall) m_pc = m_pc + 4;
        end else if (!stall) begin
          w = m_mem[(m_pc / 4) % DEPTH];
          m_instr = w; m_opc = m_pc; m_p4 = m_pc + 4; m_valid = 1;
          if (m_cnt != HALT) m_cnt = m_cnt + 1;
          if (w == HALT) m_halt = 1;
          else m_pc = m_pc + 4;
        end
      end
    end
  endtask

  task automatic tick(input logic r, input logic rn, input logic st, input logic fl,
                      input logic rd, input logic [31:0] tg, input logic we,
                      input logic [7:0] wa, input logic [31:0] wd);
    rst_n = r; run = rn; stall = st; flush = fl; redirect = rd; target = tg;
    wr_en = we; wr_addr = wa; wr_data = wd;
    model_step();
    @(posedge clk);
    #1;
    chk("model_instr", instr, m_instr);
    chk("model_pc", pc, m_opc);
    chk("model_pc_plus4", pc_plus4, m_p4);
    chk("model_valid", {31'd0, valid}, {31'd0, m_valid});
    chk("model_halted", {31'd0, halted}, {31'd0, m_halt});
`ifdef FETCH_PERF_COUNT_EN
    chk("model_count", fetch_count, m_cnt);
`endif
  endtask

  task automatic go(input logic st, input logic fl, input logic rd, input logic [31:0] tg);
    tick(1'b1, 1'b1, st, fl, rd, tg, 1'b0, 8'd0, 32'd0);
  endtask

  task automatic wr(input logic rn, input logic [7:0] a, input logic [31:0] d);
    tick(1'b1, rn, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, a, d);
  endtask

  task automatic rst();
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 8'd0, 32'd0);
  endtask

  initial begin
    tbl[0] = '{32'h0022_1820, 32'h0, 1'b1, 1'b0};
    tbl[1] = '{32'h8C43_0004, 32'h4, 1'b1, 1'b0};
    tbl[2] = '{HALT,          32'h8, 1'b1, 1'b1};
    tbl[3] = '{32'h0,         32'h8, 1'b0, 1'b1};
    tbl[4] = '{32'h0,         32'h8, 1'b0, 1'b1};

    rst();
    chk("reset_instr", instr, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);

    for (int i = 0; i < DEPTH; i++) wr(1'b0, 8'(i), seqw(i));
    wr(1'b0, 8'd0, 32'h0022_1820);
    wr(1'b0, 8'd1, 32'h8C43_0004);
    wr(1'b0, 8'd2, HALT);
    rst();
    for (int i = 0; i < 5; i++) begin
      go(1'b0, 1'b0, 1'b0, 32'd0);
      chk($sformatf("tbl%0d_instr", i), instr, tbl[i].exp_instr);
      chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
      chk($sformatf("tbl%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].exp_valid});
      chk($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].exp_halted});
    end
    go(1'b0, 1'b0, 1'b1, 32'h100);
    chk("redirect_ignored_halted", {31'd0, halted}, 32'd1);

    for (int i = 0; i < 3; i++) wr(1'b0, 8'(i), seqw(i));
    rst();

    // Stall two cycles at PC=8
    go(1'b0, 1'b0, 1'b0, 32'd0);
    go(1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 2; i++) begin
      go(1'b1, 1'b0, 1'b0, 32'd0);
      chk("stall_pc", pc, 32'h4);
      chk("stall_instr", instr, seqw(1));
    end
    go(1'b0, 1'b0, 1'b0, 32'd0);
    chk("resume_pc", pc, 32'h8);
    chk("resume_instr", instr, seqw(2));

    // Redirect beats stall
    go(1'b1, 1'b0, 1'b1, 32'h23);
    chk("redir_valid", {31'd0, valid}, 32'd0);
    chk("redir_pc_hold", pc, 32'h8);
    go(1'b0, 1'b0, 1'b0, 32'd0);
    chk("redir_pc", pc, 32'h20);
    chk("redir_instr", instr, seqw(8));

    // One-cycle flush at PC=4
    rst();
    go(1'b0, 1'b0, 1'b0, 32'd0);
    go(1'b0, 1'b1, 1'b0, 32'd0);
    chk("flush_instr", instr, 32'd0);
    chk("flush_valid", {31'd0, valid}, 32'd0);
    go(1'b0, 1'b0, 1'b0, 32'd0);
    chk("flush_next_pc", pc, 32'h8);
    chk("flush_next_p4", pc_plus4, 32'hC);

    // Write ignored while running, accepted while idle
    wr(1'b1, 8'd5, 32'hDEAD_BEEF);
    go(1'b0, 1'b0, 1'b1, 32'h14);
    go(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wr_run_ignored", instr, seqw(5));
    wr(1'b0, 8'd5, 32'hDEAD_BEEF);
    go(1'b0, 1'b0, 1'b1, 32'h14);
    go(1'b0, 1'b0, 1'b0, 32'd0);
    chk("wr_idle_instr", instr, 32'hDEAD_BEEF);
    chk("wr_idle_pc", pc, 32'h14);

    // Mid-run reset at PC=0x40
    go(1'b0, 1'b0, 1'b1, 32'h40);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h80, 1'b0, 8'd0, 32'd0);
    chk("midrst_pc", pc, 32'd0);
    chk("midrst_p4", pc_plus4, 32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    go(1'b0, 1'b0, 1'b0, 32'd0);
    chk("restart_pc", pc, 32'd0);
    chk("restart_instr", instr, seqw(0));

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      logic r, rn, we;
      logic [31:0] wd;
      r  = ($urandom_range(0, 49) != 0);
      rn = ($urandom_range(0, 3) != 0);
      we = ($urandom_range(0, 2) == 0);
      wd = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      tick(r, rn, ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 9) == 0), 32'($urandom_range(0, 1100)) | ($urandom & 32'hFFFF_0000),
           we, 8'($urandom_range(0, 255)), wd);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
